// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start/data/parity/stop framing on
// device clock falls, ACK check. Optional retry on NACK/timeout: PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5500,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int unsigned MAX_RETRIES    = 2
`endif
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_error,
  output logic       tx_active,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int unsigned TW = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  logic [RW-1:0] retry_cnt;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic          clk_oe, dat_oe;
  logic          clk_s1, sync_clk, clk_prev;
  logic          dat_s1, sync_dat;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic [7:0]    cmd_reg;
  logic          parity;
  logic          fall;
  logic          fail;

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;
  assign fall    = clk_prev & ~sync_clk;

  // A NACK is only visible on the ACK fall; every other failure is a timer expiry
  always_comb begin
    fail = 1'b0;
    case (state)
      S_START, S_SEND: fail = ~fall & (timer == '0);
      S_WAIT_ACK:      fail = fall ? sync_dat : (timer == '0);
      S_WAIT_IDLE:     fail = ~(sync_clk & sync_dat) & (timer == '0);
      default:         fail = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      clk_oe    <= 1'b0;
      dat_oe    <= 1'b0;
      clk_s1    <= 1'b1;
      sync_clk  <= 1'b1;
      clk_prev  <= 1'b1;
      dat_s1    <= 1'b1;
      sync_dat  <= 1'b1;
      timer     <= '0;
      bit_cnt   <= '0;
      cmd_reg   <= '0;
      parity    <= 1'b0;
      cmd_ready <= 1'b1;
      tx_active <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      clk_s1   <= PS2_CLK;
      sync_clk <= clk_s1;
      clk_prev <= sync_clk;
      dat_s1   <= PS2_DAT;
      sync_dat <= dat_s1;
      if (timer != '0) timer <= timer - 1'b1;

      if (fail) begin
        clk_oe    <= 1'b0;
        dat_oe    <= 1'b0;
        state     <= S_ERROR;
        cmd_error <= 1'b1;
`ifdef PS2_TX_RETRY_EN
        // Retry re-enters inhibit directly: data released, clock pulled low again
        if (retry_cnt < RW'(MAX_RETRIES)) begin
          retry_cnt <= retry_cnt + 1'b1;
          clk_oe    <= 1'b1;
          state     <= S_INHIBIT;
          cmd_error <= 1'b0;
          bit_cnt   <= '0;
          timer     <= TW'(INHIBIT_CYCLES - 1);
        end
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
              cmd_reg   <= cmd_data;
              parity    <= ~^cmd_data;
              bit_cnt   <= '0;
              clk_oe    <= 1'b1;
              cmd_ready <= 1'b0;
              tx_active <= 1'b1;
              timer     <= TW'(INHIBIT_CYCLES - 1);
              state     <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry_cnt <= '0;
`endif
            end
          end
          S_INHIBIT: begin
            clk_oe <= 1'b1;
            if (timer == '0) begin
              clk_oe <= 1'b0;
              dat_oe <= 1'b1;
              timer  <= TW'(START_TIMEOUT - 1);
              state  <= S_START;
            end
          end
          S_START: begin
            dat_oe <= 1'b1;
            if (fall) begin
              dat_oe  <= ~cmd_reg[0];
              bit_cnt <= 4'd1;
              timer   <= TW'(XFER_TIMEOUT - 1);
              state   <= S_SEND;
            end
          end
          S_SEND: begin
            if (fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              timer   <= TW'(XFER_TIMEOUT - 1);
              if (bit_cnt == 4'd8) begin
                dat_oe <= ~parity;
              end else if (bit_cnt == 4'd9) begin
                dat_oe <= 1'b0;
                state  <= S_WAIT_ACK;
              end else begin
                dat_oe <= ~cmd_reg[bit_cnt[2:0]];
              end
            end
          end
          S_WAIT_ACK: begin
            if (fall) begin
              timer <= TW'(XFER_TIMEOUT - 1);
              state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (sync_clk && sync_dat) begin
              cmd_done <= 1'b1;
              state    <= S_DONE;
            end
          end
          S_DONE: begin
            cmd_done  <= 1'b0;
            cmd_ready <= 1'b1;
            tx_active <= 1'b0;
            state     <= S_IDLE;
          end
          S_ERROR: begin
            cmd_error <= 1'b0;
            cmd_ready <= 1'b1;
            tx_active <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: vector table of frames plus timeout and
// mid-frame reset sequences against a simple PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH = 40;
  localparam int unsigned STO = 300;
  localparam int unsigned XTO = 120;
  localparam int HALF  = 8;
  localparam int BOUND = 4000;
  localparam int NV    = 5;

  typedef struct {
    logic [7:0] cmd;
    logic       par;
    int         nacks;
    int         frames;
    int         done;
    int         err;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, cmd_done, cmd_error, tx_active;
  wire        ps2_clk, ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_done (cmd_done),
    .cmd_error(cmd_error),
    .tx_active(tx_active),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_done = 0, n_err = 0, n_both = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (cmd_done) n_done <= n_done + 1;
    if (cmd_error) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (cmd_done && cmd_error) n_both <= n_both + 1;
  end

  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  logic [9:0] fr_bits;
  logic       fr_start;
  int         fr_low, fr_rel, fr_last;
  int         fr_ok;

  // Device: measure inhibit, then clock n_falls falls; bits sampled before each rise.
  task automatic dev_frame(input int n_falls, input bit nack);
    int t;
    t = 0;
    fr_bits = '0; fr_start = 1'b1; fr_low = 0; fr_ok = 1; fr_rel = 0; fr_last = 0;
    while (ps2_clk !== 1'b0 && t < BOUND) begin @(negedge clk); t++; end
    while (ps2_clk === 1'b0 && fr_low < BOUND) begin @(negedge clk); fr_low++; end
    if (t >= BOUND || fr_low >= BOUND) begin
      fr_ok = 0;
      return;
    end
    fr_rel   = cyc;
    fr_start = ps2_dat;
    for (int i = 0; i < n_falls; i++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      fr_last = cyc;
      repeat (HALF) @(negedge clk);
      if (i < 10) fr_bits[i] = ps2_dat;
      dev_clk_low = 1'b0;
      if (i == 9) dev_dat_low = !nack;
    end
    repeat (HALF) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic issue(input logic [7:0] c);
    @(negedge clk);
    cmd_data  = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int d0, input int e0, input string name);
    int t;
    t = 0;
    while (n_done == d0 && n_err == e0 && t < BOUND) begin @(negedge clk); t++; end
    chk(name, int'(t < BOUND), 1);
  endtask

  task automatic post_chk(input string tag, input int d0, input int e0,
                          input int exp_d, input int exp_e);
    repeat (5) @(negedge clk);
    chk({tag, "_done_cnt"},  n_done - d0, exp_d);
    chk({tag, "_error_cnt"}, n_err - e0, exp_e);
    chk({tag, "_ready"},     int'(cmd_ready), 1);
    chk({tag, "_active"},    int'(tx_active), 0);
    chk({tag, "_clk_line"},  int'(ps2_clk), 1);
    chk({tag, "_dat_line"},  int'(ps2_dat), 1);
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] c, input logic p, input int first);
    chk({tag, "_frame_seen"}, fr_ok, 1);
    if (first != 0) chk({tag, "_inhibit_len"}, int'(fr_low >= int'(INH)), 1);
    chk({tag, "_start_bit"}, int'(fr_start), 0);
    chk({tag, "_data_bits"}, int'(fr_bits[7:0]), int'(c));
    chk({tag, "_parity"},    int'(fr_bits[8]), int'(p));
    chk({tag, "_stop"},      int'(fr_bits[9]), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[NV];
    int   d0, e0;
`ifdef PS2_TX_RETRY_EN
    vecs[0] = '{8'hF4, 1'b0, 0, 1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 2, 3, 1, 0};
    vecs[2] = '{8'hA5, 1'b1, 3, 3, 0, 1};
    vecs[3] = '{8'h01, 1'b0, 0, 1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 2, 1, 0};
`else
    vecs[0] = '{8'hF4, 1'b0, 0, 1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 1, 0, 1};
    vecs[2] = '{8'hA5, 1'b1, 0, 1, 1, 0};
    vecs[3] = '{8'h01, 1'b0, 0, 1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 1, 0, 1};
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready",  int'(cmd_ready), 1);
    chk("rst_active", int'(tx_active), 0);
    chk("rst_done",   int'(cmd_done), 0);
    chk("rst_error",  int'(cmd_error), 0);
    chk("rst_clk",    int'(ps2_clk), 1);
    chk("rst_dat",    int'(ps2_dat), 1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      d0 = n_done;
      e0 = n_err;
      issue(vecs[k].cmd);
      chk($sformatf("v%0d_accept_active", k), int'(tx_active), 1);
      chk($sformatf("v%0d_accept_ready", k),  int'(cmd_ready), 0);
      for (int f = 0; f < vecs[k].frames; f++) begin
        fork
          dev_frame(11, f < vecs[k].nacks);
          if (f == 0) begin
            @(negedge clk);
            cmd_data  = ~vecs[k].cmd;
            cmd_valid = 1'b1;
            repeat (4) @(negedge clk);
            cmd_valid = 1'b0;
          end
        join
        frame_chk($sformatf("v%0d_f%0d", k, f), vecs[k].cmd, vecs[k].par, int'(f == 0));
      end
      wait_pulse(d0, e0, $sformatf("v%0d_pulse_wait", k));
      post_chk($sformatf("v%0d", k), d0, e0, vecs[k].done, vecs[k].err);
    end

    // Device never clocks
    d0 = n_done; e0 = n_err;
    issue(8'hFF);
    dev_frame(0, 1'b0);
    chk("sto_frame_seen", fr_ok, 1);
    chk("sto_start_bit", int'(fr_start), 0);
    wait_pulse(d0, e0, "sto_pulse_wait");
`ifndef PS2_TX_RETRY_EN
    chk("sto_cycles", err_cyc - fr_rel, int'(STO));
`endif
    post_chk("sto", d0, e0, 0, 1);

    // Device stops after the fourth fall
    d0 = n_done; e0 = n_err;
    issue(8'hF4);
    dev_frame(4, 1'b0);
    chk("xto_frame_seen", fr_ok, 1);
    chk("xto_bits", int'(fr_bits[3:0]), 4);
    wait_pulse(d0, e0, "xto_pulse_wait");
`ifndef PS2_TX_RETRY_EN
    chk("xto_cycles", err_cyc - fr_last, int'(XTO) + 3);
`endif
    post_chk("xto", d0, e0, 0, 1);

    // Reset while data bit 5 (a 0) is driven
    d0 = n_done; e0 = n_err;
    issue(8'h00);
    dev_frame(6, 1'b0);
    chk("mid_bit5_driven", int'(ps2_dat), 0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_clk",    int'(ps2_clk), 1);
    chk("mid_rst_dat",    int'(ps2_dat), 1);
    chk("mid_rst_ready",  int'(cmd_ready), 1);
    chk("mid_rst_active", int'(tx_active), 0);
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done",  n_done - d0, 0);
    chk("mid_rst_no_error", n_err - e0, 0);

    d0 = n_done; e0 = n_err;
    issue(8'hF4);
    dev_frame(11, 1'b0);
    frame_chk("after_rst", 8'hF4, 1'b0, 1);
    wait_pulse(d0, e0, "after_rst_pulse_wait");
    post_chk("after_rst", d0, e0, 1, 0);

    chk("never_both", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
